// File: rtl/mul_weight_sched_if.sv
// rtl/mul_weight_sched_if.sv - sequencer <-> MUL group-multiplier control and weight bus
interface mul_weight_sched_if #(
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16
);
  logic                              mul_configure;
  logic [LOG_MAX_ITERS-1:0]          mul_num_iters;
  logic [LOG_MAX_READS_PER_ITER-1:0] mul_num_reads_per_iter;
  logic [DATA_WIDTH-1:0]             mul_weight_data;
  logic                              mul_weight_valid;
  logic                              mul_valid_in;
  logic                              mul_avail_out;

  modport master (
    output mul_configure, mul_num_iters, mul_num_reads_per_iter,
    output mul_weight_data, mul_weight_valid, mul_avail_out,
    input  mul_valid_in
  );

  modport slave (
    input  mul_configure, mul_num_iters, mul_num_reads_per_iter,
    input  mul_weight_data, mul_weight_valid, mul_avail_out,
    output mul_valid_in
  );
endinterface

// File: rtl/mul_weight_sched.sv
// rtl/mul_weight_sched.sv - per-iteration weight sequencer for one MUL instance
// Optional stall counter: define MUL_WEIGHT_SCHED_PERF_EN.
module mul_weight_sched #(
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int WBUF_SLOTS             = 8,
  parameter int LOG_WBUF_SLOTS         = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [LOG_MAX_ITERS-1:0]          cfg_num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] cfg_num_reads_per_iter,
  output logic                              busy,
  output logic                              done,
  input  logic [DATA_WIDTH-1:0]             w_data_in,
  input  logic                              w_valid_in,
  output logic                              w_avail_out,
  mul_weight_sched_if.master                mul,
  input  logic                              down_avail_in,
  output logic [31:0]                       perf_stall_cycles
);

  typedef enum logic [2:0] {IDLE, FIRST_W, RUN, NEXT_W, DONE_S} state_t;

  localparam logic [LOG_WBUF_SLOTS:0]   SLOTS    = (LOG_WBUF_SLOTS+1)'(WBUF_SLOTS);
  localparam logic [LOG_WBUF_SLOTS-1:0] LAST_PTR = LOG_WBUF_SLOTS'(WBUF_SLOTS - 1);

  state_t                            state;
  logic [DATA_WIDTH-1:0]             fifo_mem [WBUF_SLOTS];
  logic [LOG_WBUF_SLOTS-1:0]         wr_ptr, rd_ptr;
  logic [LOG_WBUF_SLOTS:0]           count;
  logic                              full, empty, push, pop;
  logic [LOG_MAX_ITERS-1:0]          iter_cnt;
  logic [LOG_MAX_READS_PER_ITER-1:0] read_cnt;

  assign full        = (count == SLOTS);
  assign empty       = (count == '0);
  assign w_avail_out = rst & ~full;
  assign push        = w_valid_in & ~full;
  assign pop         = ((state == FIRST_W) || (state == NEXT_W)) & ~empty;

  // The multiplier only runs in RUN, so a pending weight always lands between iterations.
  assign mul.mul_avail_out = down_avail_in & (state == RUN);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= w_data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                      <= IDLE;
      busy                       <= 1'b0;
      done                       <= 1'b0;
      mul.mul_configure          <= 1'b0;
      mul.mul_weight_valid       <= 1'b0;
      mul.mul_weight_data        <= '0;
      mul.mul_num_iters          <= '0;
      mul.mul_num_reads_per_iter <= '0;
      iter_cnt                   <= '0;
      read_cnt                   <= '0;
      wr_ptr                     <= '0;
      rd_ptr                     <= '0;
      count                      <= '0;
    end else begin
      done                 <= 1'b0;
      mul.mul_configure    <= 1'b0;
      mul.mul_weight_valid <= 1'b0;

      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr              <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        mul.mul_weight_data <= fifo_mem[rd_ptr];
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            mul.mul_num_iters          <= cfg_num_iters;
            mul.mul_num_reads_per_iter <= cfg_num_reads_per_iter;
            busy                       <= 1'b1;
            if ((cfg_num_iters == '0) || (cfg_num_reads_per_iter == '0)) state <= DONE_S;
            else                                                          state <= FIRST_W;
          end
        end
        FIRST_W: begin
          if (!empty) begin
            mul.mul_configure    <= 1'b1;
            mul.mul_weight_valid <= 1'b1;
            iter_cnt             <= LOG_MAX_ITERS'(1);
            read_cnt             <= '0;
            state                <= RUN;
          end
        end
        RUN: begin
          if (mul.mul_valid_in) begin
            if (read_cnt == mul.mul_num_reads_per_iter - 1'b1) begin
              read_cnt <= '0;
              if (iter_cnt == mul.mul_num_iters) begin
                state <= DONE_S;
              end else begin
                iter_cnt <= iter_cnt + 1'b1;
                state    <= NEXT_W;
              end
            end else begin
              read_cnt <= read_cnt + 1'b1;
            end
          end
        end
        NEXT_W: begin
          if (!empty) begin
            mul.mul_weight_valid <= 1'b1;
            state                <= RUN;
          end
        end
        DONE_S: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL_WEIGHT_SCHED_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      perf_cnt <= '0;
    end else if (((state == FIRST_W) || (state == NEXT_W)) && empty && (perf_cnt != '1)) begin
      perf_cnt <= perf_cnt + 1'b1;
    end
  end

  assign perf_stall_cycles = perf_cnt;
`else
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mul_weight_sched.sv
// tb/tb_mul_weight_sched.sv - randomized self-checking bench for mul_weight_sched
module tb_mul_weight_sched;
  localparam int DW = 8;
  localparam int LI = 16;
  localparam int LR = 16;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, w_valid, w_avail, down;
  logic [LI-1:0] cfg_i;
  logic [LR-1:0] cfg_r;
  logic [DW-1:0] w_data;
  logic [31:0]   perf;

  always #5 clk = ~clk;

  mul_weight_sched_if #(.DATA_WIDTH(DW), .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR)) mif ();

  mul_weight_sched #(.DATA_WIDTH(DW), .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR),
                     .WBUF_SLOTS(8), .LOG_WBUF_SLOTS(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_num_iters(cfg_i), .cfg_num_reads_per_iter(cfg_r),
    .busy(busy), .done(done),
    .w_data_in(w_data), .w_valid_in(w_valid), .w_avail_out(w_avail),
    .mul(mif), .down_avail_in(down), .perf_stall_cycles(perf)
  );

  int checks = 0;
  int errors = 0;

  // job-level reference model
  logic [DW-1:0] q[$];
  bit            m_active, m_wait, m_first, m_fin;
  bit            e_busy, e_done, e_wv, e_cfg;
  logic [DW-1:0] e_wd;
  logic [LI-1:0] e_ni;
  logic [LR-1:0] e_nr;
  longint        m_mults;
  int            e_perf;

  // observations of the DUT
  int            dut_pulses, cfg_seen, done_seen, obs_mults;
  logic [DW-1:0] wlog[$];
  int            mv_mode, down_mode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit push, pop;
    pop = 0;
    if (!rst) begin
      q.delete();
      m_active = 0; m_wait = 0; m_first = 0; m_fin = 0;
      e_busy = 0; e_done = 0; e_wv = 0; e_cfg = 0;
      e_wd = '0; e_ni = '0; e_nr = '0; m_mults = 0; e_perf = 0;
      return;
    end
    e_done = 0; e_wv = 0; e_cfg = 0;
    push = w_valid && (q.size() < 8);
    if (m_fin) begin
      e_done = 1; e_busy = 0; m_fin = 0;
    end else if (!m_active) begin
      if (start) begin
        e_busy = 1; e_ni = cfg_i; e_nr = cfg_r; e_perf = 0;
        dut_pulses = 0; m_mults = 0;
        if (cfg_i == 0 || cfg_r == 0) m_fin = 1;
        else begin m_active = 1; m_wait = 1; m_first = 1; end
      end
    end else if (m_wait) begin
      if (q.size() > 0) begin
        pop = 1; e_wv = 1; e_cfg = m_first; e_wd = q[0];
        m_wait = 0; m_first = 0;
      end else begin
`ifdef MUL_WEIGHT_SCHED_PERF_EN
        e_perf++;
`endif
      end
    end else if (mif.mul_valid_in) begin
      chk("weight_index", 64'(dut_pulses), 64'(m_mults / longint'(e_nr) + 1));
      m_mults++;
      if (m_mults == longint'(e_ni) * longint'(e_nr)) begin
        m_fin = 1; m_active = 0;
      end else if (m_mults % longint'(e_nr) == 0) begin
        m_wait = 1;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(w_data);
  endtask

  task automatic compare();
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("weight_valid", 64'(mif.mul_weight_valid), 64'(e_wv));
    chk("configure", 64'(mif.mul_configure), 64'(e_cfg));
    chk("weight_data", 64'(mif.mul_weight_data), 64'(e_wd));
    chk("num_iters", 64'(mif.mul_num_iters), 64'(e_ni));
    chk("num_reads", 64'(mif.mul_num_reads_per_iter), 64'(e_nr));
    chk("w_avail", 64'(w_avail), 64'(rst && q.size() < 8));
    chk("mul_avail", 64'(mif.mul_avail_out), 64'(rst && m_active && !m_wait && down));
    chk("perf", 64'(perf), 64'(e_perf));
    if (mif.mul_weight_valid) begin
      dut_pulses++;
      wlog.push_back(mif.mul_weight_data);
    end
    if (mif.mul_configure) cfg_seen++;
    if (done) done_seen++;
  endtask

  task automatic tick();
    case (down_mode)
      1: down = ~down;
      2: down = 1'($urandom_range(0, 1));
      default: ;
    endcase
    #1;
    if (mv_mode == 1) mif.mul_valid_in = 1'($urandom_range(0, 1));
    else if (mv_mode == 2) mif.mul_valid_in = mif.mul_avail_out;
    if (mif.mul_avail_out && mif.mul_valid_in) obs_mults++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic push_w(input logic [DW-1:0] d);
    w_valid = 1'b1; w_data = d;
    tick();
    w_valid = 1'b0;
  endtask

  task automatic do_start(input int ni, input int nr);
    cfg_i = LI'(ni); cfg_r = LR'(nr); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_done(input int max);
    int n = 0;
    while (!done && n < max) begin tick(); n++; end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  task automatic clear_obs();
    wlog.delete(); cfg_seen = 0; obs_mults = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] exp_t1 [3];
    logic [DW-1:0] exp_t4 [8];
    int n, snap, ds;
    exp_t1 = '{8'd2, 8'd3, 8'd5};
    exp_t4 = '{8'd7, 8'd9, 8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55};
    rst = 0; start = 0; w_valid = 0; w_data = '0; cfg_i = '0; cfg_r = '0;
    down = 1; mif.mul_valid_in = 0; mv_mode = 0; down_mode = 0;
    dut_pulses = 0; done_seen = 0; clear_obs();
    @(negedge clk);
    repeat (3) tick();
    rst = 1;
    tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_w_avail", 64'(w_avail), 64'd1);

    // preloaded 2,3,5 with a continuously driven multiplier
    push_w(8'd2); push_w(8'd3); push_w(8'd5);
    clear_obs();
    mif.mul_valid_in = 1;
    do_start(3, 4);
    run_done(100);
    chk("t1_configures", 64'(cfg_seen), 64'd1);
    chk("t1_pulses", 64'(wlog.size()), 64'd3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) chk("t1_weight", 64'(wlog[i]), 64'(exp_t1[i]));
    chk("t1_mults", 64'(obs_mults), 64'd12);
    chk("t1_busy_at_done", 64'(busy), 64'd0);

    // weight starvation at an iteration boundary
    mv_mode = 1; clear_obs();
    w_valid = 1; w_data = 8'h11;
    do_start(2, 2);
    w_valid = 0;
    n = 0;
    while (!(dut_pulses == 1 && !mif.mul_avail_out) && n < 200) begin tick(); n++; end
    chk("t2_boundary_reached", 64'(n < 200), 64'd1);
    snap = obs_mults;
    repeat (9) begin
      tick();
      chk("t2_next_w_avail", 64'(mif.mul_avail_out), 64'd0);
    end
    push_w(8'h22);
    chk("t2_no_mult_in_stall", 64'(obs_mults), 64'(snap));
`ifdef MUL_WEIGHT_SCHED_PERF_EN
    chk("t2_perf_stall", 64'(perf), 64'd10);
`endif
    run_done(200);
    tick();
`ifdef MUL_WEIGHT_SCHED_PERF_EN
    chk("t2_perf_hold", 64'(perf), 64'd10);
`endif

    // zero-length jobs
    mv_mode = 0; mif.mul_valid_in = 0;
    push_w(8'd7); push_w(8'd9);
    clear_obs();
    do_start(0, 5);
    chk("t3_done_early", 64'(done), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    tick();
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_busy_low", 64'(busy), 64'd0);
    do_start(3, 0);
    tick();
    chk("t3b_done", 64'(done), 64'd1);
    chk("t3_no_pop", 64'(wlog.size()), 64'd0);
    chk("t3_no_configure", 64'(cfg_seen), 64'd0);

    // fill to full, overflow, then drain across pointer wrap
    for (int k = 0; k < 6; k++) push_w(8'(50 + k));
    chk("t4_full_avail", 64'(w_avail), 64'd0);
    push_w(8'd56);
    chk("t4_still_full", 64'(w_avail), 64'd0);
    clear_obs(); mv_mode = 2;
    cfg_i = 16'd12; cfg_r = 16'd1; start = 1;
    n = 0;
    while (!done && n < 200) begin
      w_valid = 1; w_data = 8'(100 + n);
      tick(); start = 0; n++;
    end
    w_valid = 0;
    chk("t4_done", 64'(done), 64'd1);
    for (int i = 0; i < 8 && i < wlog.size(); i++) chk("t4_order", 64'(wlog[i]), 64'(exp_t4[i]));

    // start while busy, then reset mid-run
    mv_mode = 2;
    push_w(8'd1); push_w(8'd2);
    do_start(5, 3);
    repeat (4) tick();
    do_start(2, 2);
    chk("t5_ignored_start", 64'(mif.mul_num_iters), 64'd5);
    repeat (2) tick();
    ds = done_seen;
    rst = 0;
    repeat (2) tick();
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_wv", 64'(mif.mul_weight_valid), 64'd0);
    chk("t5_rst_iters", 64'(mif.mul_num_iters), 64'd0);
    chk("t5_rst_avail", 64'(mif.mul_avail_out), 64'd0);
    chk("t5_rst_w_avail", 64'(w_avail), 64'd0);
    rst = 1;
    tick();
    chk("t5_no_done", 64'(done_seen), 64'(ds));

    // down_avail toggling with one read per iteration
    push_w(8'h41); push_w(8'h42);
    clear_obs(); down_mode = 1;
    do_start(2, 1);
    run_done(60);
    chk("t6_pulses", 64'(wlog.size()), 64'd2);
    chk("t6_mults", 64'(obs_mults), 64'd2);

    // randomized jobs with spurious valids and ignored starts
    mv_mode = 1; down_mode = 2;
    for (int j = 0; j < 8; j++) begin
      cfg_i = LI'($urandom_range(1, 4)); cfg_r = LR'($urandom_range(1, 4));
      start = 1;
      n = 0;
      while (!done && n < 400) begin
        w_valid = 1'($urandom_range(0, 1)); w_data = 8'($urandom);
        tick(); n++;
        start = ($urandom_range(0, 7) == 0);
        if (!done) begin
          cfg_i = LI'($urandom_range(0, 4)); cfg_r = LR'($urandom_range(0, 4));
        end
      end
      start = 0; w_valid = 0;
      chk("rand_done", 64'(done), 64'd1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
